// File: rtl/fc_func_requant.sv
// fc_func_requant: sweeps CIM output columns, sums vertical tiles, shift-requantises, saturates
// and streams one result per cycle to the next layer. Define FC_FUNC_RELU_EN to clamp negatives to 0.
module fc_func_requant #(
  parameter int INPUT_SIZE        = 201,
  parameter int OUTPUT_SIZE       = 512,
  parameter int XBAR_SIZE         = 256,
  parameter int H_CIM_TILES       = (OUTPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int V_CIM_TILES       = (INPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int DTYPE_SIZE        = 8,
  parameter int ACC_SIZE          = DTYPE_SIZE + $clog2(V_CIM_TILES) + 1,
  parameter int OUTPUT_DTYPE_SIZE = 8,
  parameter int SHIFT_W           = 5
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_start,
  input  logic                                            i_cim_busy,
  input  logic [SHIFT_W-1:0]                              i_shift,
  input  logic [V_CIM_TILES*H_CIM_TILES*DTYPE_SIZE-1:0]   i_data,
  output logic [$clog2(XBAR_SIZE)-1:0]                    o_cim_addr,
  output logic [$clog2(H_CIM_TILES):0]                    o_h_tile,
  output logic                                            o_busy,
  output logic                                            o_valid,
  input  logic                                            i_next_ready,
  output logic [OUTPUT_DTYPE_SIZE-1:0]                    o_data,
  output logic [$clog2(OUTPUT_SIZE):0]                    o_index,
  input  logic                                            i_next_busy,
  output logic                                            o_start_next
);

  localparam int ADDR_W = $clog2(XBAR_SIZE);
  localparam int TILE_W = $clog2(H_CIM_TILES) + 1;
  localparam int IDX_W  = $clog2(OUTPUT_SIZE) + 1;
  localparam int CW     = (ACC_SIZE > OUTPUT_DTYPE_SIZE) ? ACC_SIZE : OUTPUT_DTYPE_SIZE;
  localparam logic signed [CW-1:0] SAT_MAX =
    {{(CW-OUTPUT_DTYPE_SIZE+1){1'b0}}, {(OUTPUT_DTYPE_SIZE-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN =
    {{(CW-OUTPUT_DTYPE_SIZE+1){1'b1}}, {(OUTPUT_DTYPE_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWEEP, S_DRAIN, S_HANDOFF} state_t;

  state_t                     state, state_next;
  logic [SHIFT_W-1:0]         shift_reg;
  logic [IDX_W-1:0]           issue_idx;
  logic                       adv, issue, last_issue;
  logic                       s1_valid, s1_held;
  logic [TILE_W-1:0]          s1_tile;
  logic [IDX_W-1:0]           s1_idx;
  logic signed [ACC_SIZE-1:0] col_sum, hold_sum, acc, shifted, rectified;
  logic signed [CW-1:0]       wide;
  logic [OUTPUT_DTYPE_SIZE-1:0] sat_val;

  assign adv        = !o_valid || i_next_ready;
  assign last_issue = (issue_idx == IDX_W'(OUTPUT_SIZE - 1));
  assign o_busy     = (state != S_IDLE);

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    o_start_next = 1'b0;
    case (state)
      S_IDLE:    if (i_start) state_next = i_cim_busy ? S_WAIT : S_SWEEP;
      S_WAIT:    if (!i_cim_busy) state_next = S_SWEEP;
      S_SWEEP: begin
        if (adv) begin
          issue = 1'b1;
          if (last_issue) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (o_valid && i_next_ready && o_index == IDX_W'(OUTPUT_SIZE - 1))
          state_next = S_HANDOFF;
      end
      S_HANDOFF: begin
        if (!i_next_busy) begin
          o_start_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      issue_idx  <= '0;
      o_cim_addr <= '0;
      o_h_tile   <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && i_start) begin
        shift_reg  <= i_shift;
        issue_idx  <= '0;
        o_cim_addr <= '0;
        o_h_tile   <= '0;
      end else if (issue && !last_issue) begin
        issue_idx <= issue_idx + IDX_W'(1);
        if (o_cim_addr == ADDR_W'(XBAR_SIZE - 1)) begin
          o_cim_addr <= '0;
          o_h_tile   <= o_h_tile + TILE_W'(1);
        end else begin
          o_cim_addr <= o_cim_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    col_sum = '0;
    for (int v = 0; v < V_CIM_TILES; v++) begin
      for (int h = 0; h < H_CIM_TILES; h++) begin
        if (s1_tile == TILE_W'(h))
          col_sum = col_sum +
            ACC_SIZE'($signed(i_data[(v*H_CIM_TILES + h)*DTYPE_SIZE +: DTYPE_SIZE]));
      end
    end
  end

  // The tiles keep reading the held address during a stall, so the column already in S1 is
  // captured on the first stalled cycle and reused until the pipeline advances again.
  always_comb begin
    acc     = s1_held ? hold_sum : col_sum;
    shifted = acc >>> shift_reg;
`ifdef FC_FUNC_RELU_EN
    rectified = (shifted < 0) ? '0 : shifted;
`else
    rectified = shifted;
`endif
    wide = CW'(rectified);
    if (wide > SAT_MAX)      sat_val = SAT_MAX[OUTPUT_DTYPE_SIZE-1:0];
    else if (wide < SAT_MIN) sat_val = SAT_MIN[OUTPUT_DTYPE_SIZE-1:0];
    else                     sat_val = wide[OUTPUT_DTYPE_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tile  <= '0;
      s1_idx   <= '0;
      s1_held  <= 1'b0;
      hold_sum <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_index  <= '0;
    end else if (adv) begin
      s1_valid <= issue;
      s1_tile  <= o_h_tile;
      s1_idx   <= issue_idx;
      s1_held  <= 1'b0;
      o_valid  <= s1_valid;
      if (s1_valid) begin
        o_data  <= sat_val;
        o_index <= s1_idx;
      end
    end else if (s1_valid && !s1_held) begin
      s1_held  <= 1'b1;
      hold_sum <= col_sum;
    end
  end

endmodule

// File: tb/tb_fc_func_requant.sv
// Scoreboard bench for fc_func_requant: a 1-cycle-latency tile memory model feeds the DUT and
// expected outputs are queued at each start and matched against accepted outputs.
module tb_fc_func_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_cim_busy = 1'b0;
  logic        i_next_ready = 1'b1;
  logic        i_next_busy = 1'b0;
  logic [4:0]  i_shift = '0;
  logic [31:0] i_data = '0;
  logic [1:0]  o_cim_addr, o_h_tile;
  logic        o_busy, o_valid, o_start_next;
  logic [7:0]  o_data;
  logic [3:0]  o_index;

  int          mem [2][2][4];
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          start_pulses = 0;

  fc_func_requant #(
    .INPUT_SIZE(6), .OUTPUT_SIZE(5), .XBAR_SIZE(4),
    .DTYPE_SIZE(8), .OUTPUT_DTYPE_SIZE(8), .SHIFT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cim_busy(i_cim_busy), .i_shift(i_shift),
    .i_data(i_data), .o_cim_addr(o_cim_addr), .o_h_tile(o_h_tile), .o_busy(o_busy),
    .o_valid(o_valid), .i_next_ready(i_next_ready), .o_data(o_data), .o_index(o_index),
    .i_next_busy(i_next_busy), .o_start_next(o_start_next)
  );

  always #5 clk = ~clk;

  // Tile memories: registered read of o_cim_addr, one byte per (v, h) tile.
  always @(posedge clk) begin
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 2; h++)
        i_data[(v*2 + h)*8 +: 8] <= 8'(mem[v][h][o_cim_addr]);
  end

  always @(negedge clk) begin
    if (o_valid && i_next_ready) obs_q.push_back({o_index, o_data});
    if (o_start_next) start_pulses++;
  end

  function automatic logic [11:0] model(input int k, input int sh);
    int a, h, s;
    a = k % 4;
    h = k / 4;
    s = mem[0][h][a] + mem[1][h][a];
    s = s >>> sh;
`ifdef FC_FUNC_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return {4'(k), 8'(s)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(input int k, input int v0, input int v1);
    mem[0][k/4][k%4] = v0;
    mem[1][k/4][k%4] = v1;
  endtask

  task automatic start_sweep(input int sh, input bit cim_busy);
    i_shift    = 5'(sh);
    i_cim_busy = cim_busy;
    i_start    = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(model(k, sh));
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int n = 0;
    while (o_busy && n < 200) begin
      step();
      n++;
    end
    timed_out = o_busy;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run += 4;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_start_next !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got busy=%b valid=%b start=%b, want 0 0 0", o_busy, o_valid, o_start_next);
    end
    if (o_cim_addr !== 2'd0 || o_h_tile !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: got addr=%0d tile=%0d, want 0 0", o_cim_addr, o_h_tile);
    end
    if (o_index !== 4'd0 || o_data !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got idx=%0d data=%0d, want 0 0", o_index, o_data);
    end
    i_start = 1'b1;
    step();
    if (o_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_wins: got busy=%b, want 0", o_busy);
    end
    rst = 1'b0;
    i_start = 1'b0;
    step();
    tests_run++;
    if (o_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got busy=%b, want 0", o_busy);
    end
  endtask

  task automatic test_basic();
    logic [1:0]  exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0]  exp_tile [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [11:0] e, o;
    bit          timed_out;
    for (int k = 0; k < 5; k++) set_col(k, 10 + k, 10 + k);
    start_sweep(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (o_cim_addr !== exp_addr[i] || o_h_tile !== exp_tile[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_addr[%0d]: got addr=%0d tile=%0d, want %0d %0d", i, o_cim_addr, o_h_tile, exp_addr[i], exp_tile[i]);
      end
      if (i == 1) begin
        tests_run++;
        if (o_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL basic_early_valid: got valid=%b, want 0", o_valid);
        end
      end
      if (i == 2) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_index !== 4'd0 || o_data !== 8'd20) begin
          tests_failed++;
          $display("[TB] FAIL basic_latency: got valid=%b idx=%0d data=%0d, want 1 0 20", o_valid, o_index, o_data);
        end
      end
      step();
    end
    wait_idle(timed_out);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL basic_timeout: got busy=1, want 0");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hfff;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL basic_out: got idx %0d data %0d, want idx %0d data %0d", o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_extra: got %0d extra outputs, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_arith(input string name, input int sh);
    logic [11:0] e, o;
    bit          timed_out;
    start_sweep(sh, 1'b0);
    wait_idle(timed_out);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got busy=1, want 0", name);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hfff;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL %s_out: got idx %0d data %0d, want idx %0d data %0d", name, o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_extra: got %0d extra outputs, want 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_saturation();
    set_col(0, 100, 100);
    set_col(1, -100, -100);
    set_col(2, 127, 127);
    set_col(3, -128, -128);
    set_col(4, 50, -20);
    test_arith("sat", 0);
  endtask

  task automatic test_shift();
    set_col(0, 7, 6);
    set_col(1, -7, 0);
    set_col(2, -1, 0);
    set_col(3, 100, 27);
    set_col(4, -128, -128);
    test_arith("shift2", 2);
    test_arith("shift12", 12);
    test_arith("shift31", 31);
  endtask

  task automatic test_backpressure();
    logic [11:0] e, o, held;
    bit          timed_out;
    int          n = 0;
    for (int k = 0; k < 5; k++) set_col(k, 3*k + 1, 5*k - 7);
    held = model(2, 0);
    start_sweep(0, 1'b0);
    while (!(o_valid && o_index == 4'd2) && n < 20) begin
      step();
      n++;
    end
    i_next_ready = 1'b0;
    i_start      = 1'b1;
    i_shift      = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      i_start = 1'b0;
      tests_run++;
      if (o_valid !== 1'b1 || {o_index, o_data} !== held) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b idx=%0d data=%0d, want 1 %0d %0d", i, o_valid, o_index, $signed(o_data), held[11:8], $signed(held[7:0]));
      end
    end
    i_next_ready = 1'b1;
    step();
    tests_run++;
    if (o_valid !== 1'b1 || o_index !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL stall_resume: got valid=%b idx=%0d, want 1 3", o_valid, o_index);
    end
    wait_idle(timed_out);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL stall_timeout: got busy=1, want 0");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hfff;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL stall_out: got idx %0d data %0d, want idx %0d data %0d", o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_extra: got %0d extra outputs, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_wait_handoff();
    logic [11:0] e, o;
    int          n = 0;
    int          pulses0;
    for (int k = 0; k < 5; k++) set_col(k, 2*k - 4, k + 1);
    start_sweep(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (o_busy !== 1'b1 || o_cim_addr !== 2'd0 || o_h_tile !== 2'd0 || o_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wait_hold[%0d]: got busy=%b addr=%0d tile=%0d valid=%b, want 1 0 0 0", i, o_busy, o_cim_addr, o_h_tile, o_valid);
      end
      step();
    end
    i_cim_busy  = 1'b0;
    i_next_busy = 1'b1;
    while (obs_q.size() < 5 && n < 100) begin
      step();
      n++;
    end
    pulses0 = start_pulses;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (o_busy !== 1'b1 || o_start_next !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL handoff_hold[%0d]: got busy=%b start=%b, want 1 0", i, o_busy, o_start_next);
      end
      step();
    end
    i_next_busy = 1'b0;
    #1;
    tests_run++;
    if (o_start_next !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL handoff_pulse: got start=%b, want 1", o_start_next);
    end
    step();
    tests_run += 2;
    if (o_start_next !== 1'b0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL handoff_done: got start=%b busy=%b, want 0 0", o_start_next, o_busy);
    end
    if (start_pulses !== pulses0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL handoff_count: got %0d pulses, want 1", start_pulses - pulses0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hfff;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL wait_out: got idx %0d data %0d, want idx %0d data %0d", o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wait_extra: got %0d extra outputs, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    logic [11:0] e, o;
    bit          timed_out;
    int          n = 0;
    int          pulses0;
    for (int k = 0; k < 5; k++) set_col(k, 10 + k, 10 + k);
    start_sweep(0, 1'b0);
    while (!(o_valid && o_index == 4'd2) && n < 20) begin
      step();
      n++;
    end
    pulses0 = start_pulses;
    rst = 1'b1;
    #1;
    tests_run += 2;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_drop: got valid=%b busy=%b, want 0 0", o_valid, o_busy);
    end
    if (obs_q.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL abort_count: got %0d outputs before reset, want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL abort_out: got idx %0d data %0d, want idx %0d data %0d", o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    exp_q.delete();
    obs_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (start_pulses !== pulses0) begin
      tests_failed++;
      $display("[TB] FAIL abort_pulse: got %0d handoff pulses, want 0", start_pulses - pulses0);
    end
    start_sweep(0, 1'b0);
    wait_idle(timed_out);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL restart_timeout: got busy=1, want 0");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hfff;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL restart_out: got idx %0d data %0d, want idx %0d data %0d", o[11:8], $signed(o[7:0]), e[11:8], $signed(e[7:0]));
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL restart_extra: got %0d extra outputs, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_shift();
    test_backpressure();
    test_wait_handoff();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
